memory_access: RTL

Memory-access stage of the PNR-Core five-stage RISC-V pipeline. It sits between the execute stage and the write-back stage. It consumes the execute-stage pipeline register and runs a request/grant/response transaction on the data-memory port for loads and stores. It aligns and extends load data, generates store byte enables, and registers the result for write-back. While a transaction is outstanding it stalls the pipeline.

---
 rtl/pnr_core_pkg.sv | 24 ++
 rtl/memory_access_if.sv | 28 ++
 rtl/load_store_align.sv | 60 ++++++
 rtl/memory_access.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pnr_core_pkg.sv
// pnr_core_pkg
//   Shared definitions for the PNR-Core pipeline: funct3 access-size codes and
//   the memory-access stage FSM state encoding.
package pnr_core_pkg;

   // Load funct3 codes
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store funct3 codes
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      MEM_IDLE        = 2'd0,
      MEM_WAIT_GNT    = 2'd1,
      MEM_WAIT_RVALID = 2'd2
   } mem_state_e;

endpackage

// File: rtl/memory_access_if.sv
// memory_access_if
//   Data-memory request/grant/response bus.
//   master: req, we, addr (word aligned), wdata, be out; gnt, rvalid, rdata in.
//   slave : the memory side of the same bus.
interface memory_access_if #(
   parameter int unsigned XLEN = 32
) ();

   logic              req;
   logic              we;
   logic [XLEN-1:0]   addr;
   logic [XLEN-1:0]   wdata;
   logic [XLEN/8-1:0] be;
   logic              gnt;
   logic              rvalid;
   logic [XLEN-1:0]   rdata;

   modport master (
      output req, we, addr, wdata, be,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata, be,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/load_store_align.sv
// load_store_align
//   Purely combinational lane logic for the memory-access stage.
//   funct3_i     : access size / signedness
//   offset_i     : byte offset within the word (addr[1:0])
//   store_data_i : raw store data
//   rdata_i      : raw word returned by memory
//   be_o         : byte enables
//   wdata_o      : store data replicated across byte lanes
//   load_data_o  : extracted and extended load value
//   misaligned_o : access size does not fit the offset
module load_store_align
   import pnr_core_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_data_o,
   output logic        misaligned_o
);

   logic [31:0] lane;

   // Bring the addressed byte/halfword down to bit 0.
   assign lane = rdata_i >> {offset_i, 3'b000};

   assign misaligned_o = ((funct3_i[1:0] == 2'b01) && offset_i[0]) ||
                         (funct3_i[1] && (offset_i != 2'b00));

   always_comb begin
      be_o    = 4'b1111;
      wdata_o = store_data_i;
      case (funct3_i[1:0])
         F3_SB[1:0]: begin
            be_o    = 4'b0001 << offset_i;
            wdata_o = {4{store_data_i[7:0]}};
         end
         F3_SH[1:0]: begin
            be_o    = 4'b0011 << offset_i;
            wdata_o = {2{store_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      // Unlisted codes act as LW; for an aligned word lane equals rdata_i.
      load_data_o = lane;
      case (funct3_i)
         F3_LB:   load_data_o = {{24{lane[7]}}, lane[7:0]};
         F3_LH:   load_data_o = {{16{lane[15]}}, lane[15:0]};
         F3_LBU:  load_data_o = {24'h0, lane[7:0]};
         F3_LHU:  load_data_o = {16'h0, lane[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// memory_access
//   Memory-access stage of the PNR-Core pipeline. Runs the data-memory
//   request/grant/response transaction, stalls upstream while it is in
//   flight, and registers the result for write-back.
//   clk_i, rst_i (async, active high)
//   *_mem_i      : execute-stage pipeline register
//   dmem         : data-memory bus (master side)
//   mem_stall_o  : holds IF/ID/EX
//   misaligned_mem_o : current memory access is misaligned
//   *_wb_o       : write-back pipeline register
module memory_access
   import pnr_core_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,

   input  logic [XLEN-1:0] alu_result_mem_i,
   input  logic [XLEN-1:0] latest_rs2_value_mem_i,
   input  logic            load_store_forward_sel_mem_i,
   input  logic            reg_write_en_mem_i,
   input  logic            is_load_instr_mem_i,
   input  logic            is_store_instr_mem_i,
   input  logic [4:0]      rd_label_mem_i,
   input  logic [1:0]      wb_sel_mem_i,
   input  logic [XLEN-1:0] pc_mem_i,
   input  logic [2:0]      funct3_mem_i,

   memory_access_if.master dmem,

   output logic            mem_stall_o,
   output logic            misaligned_mem_o,

   output logic [XLEN-1:0] alu_result_wb_o,
   output logic [XLEN-1:0] load_data_wb_o,
   output logic [XLEN-1:0] pc_wb_o,
   output logic            reg_write_en_wb_o,
   output logic            is_load_instr_wb_o,
   output logic [4:0]      rd_label_wb_o,
   output logic [1:0]      wb_sel_wb_o
);

   mem_state_e      state_q, state_d;
   logic            is_mem;
   logic            misaligned_raw;
   logic            pending;
   logic            req;
   logic            capture_load;
   logic [XLEN-1:0] store_src;
   logic [3:0]      be;
   logic [XLEN-1:0] wdata;
   logic [XLEN-1:0] load_aligned;

   assign is_mem           = is_load_instr_mem_i | is_store_instr_mem_i;
   assign misaligned_mem_o = is_mem & misaligned_raw;
   assign pending          = is_mem & ~misaligned_raw;

   // Load->store back-to-back: the store data is the value just loaded.
   assign store_src = load_store_forward_sel_mem_i ? load_data_wb_o : latest_rs2_value_mem_i;

   load_store_align u_align (
      .funct3_i     (funct3_mem_i),
      .offset_i     (alu_result_mem_i[1:0]),
      .store_data_i (store_src),
      .rdata_i      (dmem.rdata),
      .be_o         (be),
      .wdata_o      (wdata),
      .load_data_o  (load_aligned),
      .misaligned_o (misaligned_raw)
   );

   // State register; reset abandons any outstanding transaction.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= MEM_IDLE;
      else       state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         MEM_IDLE: begin
            if (pending) begin
               if (!dmem.gnt)               state_d = MEM_WAIT_GNT;
               else if (is_load_instr_mem_i) state_d = MEM_WAIT_RVALID;
            end
         end
         MEM_WAIT_GNT: begin
            if (dmem.gnt) state_d = is_store_instr_mem_i ? MEM_IDLE : MEM_WAIT_RVALID;
         end
         MEM_WAIT_RVALID: begin
            if (dmem.rvalid) state_d = MEM_IDLE;
         end
         default: state_d = MEM_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      req          = 1'b0;
      mem_stall_o  = 1'b0;
      capture_load = 1'b0;
      unique case (state_q)
         MEM_IDLE: begin
            req         = pending;
            mem_stall_o = pending & ~(dmem.gnt & is_store_instr_mem_i);
         end
         MEM_WAIT_GNT: begin
            req         = 1'b1;
            mem_stall_o = ~(dmem.gnt & is_store_instr_mem_i);
         end
         MEM_WAIT_RVALID: begin
            mem_stall_o  = ~dmem.rvalid;
            capture_load = dmem.rvalid;
         end
         default: ;
      endcase
   end

   // Bus fields are driven only alongside req so the bus idles at zero.
   assign dmem.req   = req;
   assign dmem.we    = req & is_store_instr_mem_i;
   assign dmem.addr  = req ? {alu_result_mem_i[XLEN-1:2], 2'b00} : '0;
   assign dmem.wdata = req ? wdata : '0;
   assign dmem.be    = req ? be : '0;

   // Write-back register; a stall inserts a bubble.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         alu_result_wb_o    <= '0;
         load_data_wb_o     <= '0;
         pc_wb_o            <= '0;
         reg_write_en_wb_o  <= 1'b0;
         is_load_instr_wb_o <= 1'b0;
         rd_label_wb_o      <= '0;
         wb_sel_wb_o        <= '0;
      end else begin
         // load_data_wb_o only changes on a returned load so it stays
         // available for a following forwarded store.
         if (capture_load) load_data_wb_o <= load_aligned;
         if (mem_stall_o) begin
            reg_write_en_wb_o  <= 1'b0;
            is_load_instr_wb_o <= 1'b0;
         end else begin
            alu_result_wb_o    <= alu_result_mem_i;
            pc_wb_o            <= pc_mem_i;
            reg_write_en_wb_o  <= reg_write_en_mem_i & ~misaligned_mem_o;
            is_load_instr_wb_o <= is_load_instr_mem_i;
            rd_label_wb_o      <= rd_label_mem_i;
            wb_sel_wb_o        <= wb_sel_mem_i;
         end
      end
   end

endmodule
